// File: rtl/c8_misr_capture.sv
// Response compactor for c8 outputs: folds 18-bit vectors into a MISR
// and counts accepted vectors and po17 hits over a programmed run.
module c8_misr_capture #(
    parameter logic [17:0] SEED  = 18'h00000,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] num_vectors,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [17:0]      in_data,
    output logic             busy,
    output logic             done,
    output logic [17:0]      signature,
    output logic [CNT_W-1:0] vec_count,
    output logic [CNT_W-1:0] hit_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [17:0]      sig_q, sig_d;
    logic [CNT_W-1:0] vec_q, vec_d;
    logic [CNT_W-1:0] hit_q, hit_d;
    logic [CNT_W-1:0] tgt_q, tgt_d;
    logic             fb;
    logic             beat;

    assign fb   = sig_q[17] ^ sig_q[10];
    assign beat = (state_q == RUN) && in_valid;

    always_comb begin
        state_d = state_q;
        sig_d   = sig_q;
        vec_d   = vec_q;
        hit_d   = hit_q;
        tgt_d   = tgt_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (start) begin
                    sig_d   = SEED;
                    vec_d   = '0;
                    hit_d   = '0;
                    tgt_d   = num_vectors;
                    state_d = (num_vectors == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (beat) begin
                    sig_d = {sig_q[16:0], fb} ^ in_data;
                    vec_d = vec_q + CNT_W'(1);
                    hit_d = hit_q + CNT_W'(in_data[17]);
                    if (vec_d == tgt_q) begin
                        state_d = DONE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            sig_q   <= '0;
            vec_q   <= '0;
            hit_q   <= '0;
            tgt_q   <= '0;
        end else begin
            state_q <= state_d;
            sig_q   <= sig_d;
            vec_q   <= vec_d;
            hit_q   <= hit_d;
            tgt_q   <= tgt_d;
        end
    end

    assign in_ready  = (state_q == RUN);
    assign busy      = (state_q == RUN);
    assign done      = (state_q == DONE);
    assign signature = sig_q;
    assign vec_count = vec_q;
    assign hit_count = hit_q;

endmodule

// File: tb/tb_c8_misr_capture.sv
// Directed bench for c8_misr_capture: two instances share stimulus,
// one with a zero seed and one with seed 18'h20400.
module tb_c8_misr_capture;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic        abort;
    logic [15:0] num_vectors;
    logic        in_valid;
    logic [17:0] in_data;

    logic        in_ready, busy, done;
    logic [17:0] signature;
    logic [15:0] vec_count, hit_count;

    logic        in_ready2, busy2, done2;
    logic [17:0] signature2;
    logic [15:0] vec_count2, hit_count2;

    int compared   = 0;
    int mismatched = 0;

    always #5 clock = ~clock;

    c8_misr_capture #(.SEED(18'h00000), .CNT_W(16)) dut (
        .clock(clock), .reset(reset), .start(start), .abort(abort),
        .num_vectors(num_vectors), .in_valid(in_valid),
        .in_ready(in_ready), .in_data(in_data), .busy(busy),
        .done(done), .signature(signature), .vec_count(vec_count),
        .hit_count(hit_count)
    );

    c8_misr_capture #(.SEED(18'h20400), .CNT_W(16)) dut2 (
        .clock(clock), .reset(reset), .start(start), .abort(abort),
        .num_vectors(num_vectors), .in_valid(in_valid),
        .in_ready(in_ready2), .in_data(in_data), .busy(busy2),
        .done(done2), .signature(signature2), .vec_count(vec_count2),
        .hit_count(hit_count2)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic go(input logic [15:0] n);
        start       = 1'b1;
        num_vectors = n;
        tick();
        start       = 1'b0;
    endtask

    task automatic beat(input logic [17:0] d);
        in_valid = 1'b1;
        in_data  = d;
        tick();
        in_valid = 1'b0;
    endtask

    logic [17:0] vecs [4];
    logic        pat  [6];

    initial begin
        int j;
        vecs[0] = 18'h00001; vecs[1] = 18'h20000;
        vecs[2] = 18'h00003; vecs[3] = 18'h3FFFF;
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b1;
        pat[3] = 1'b1; pat[4] = 1'b0; pat[5] = 1'b1;

        reset = 1'b1; start = 1'b0; abort = 1'b0;
        num_vectors = '0; in_valid = 1'b0; in_data = '0;
        tick(); tick();
        reset = 1'b0;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd0);
        chk("rst_sig", 32'(signature), 32'd0);
        chk("rst_vec", 32'(vec_count), 32'd0);
        chk("rst_hit", 32'(hit_count), 32'd0);

        // shift and feedback
        go(16'd3);
        chk("run_busy", 32'(busy), 32'd1);
        chk("run_ready", 32'(in_ready), 32'd1);
        chk("run_seed", 32'(signature), 32'h0);
        beat(18'h00001);
        chk("sh_sig1", 32'(signature), 32'h00001);
        beat(18'h00000);
        chk("sh_sig2", 32'(signature), 32'h00002);
        beat(18'h20000);
        chk("sh_sig3", 32'(signature), 32'h20004);
        chk("sh_done", 32'(done), 32'd1);
        chk("sh_vec", 32'(vec_count), 32'd3);
        chk("sh_hit", 32'(hit_count), 32'd1);
        chk("sh_ready", 32'(in_ready), 32'd0);

        // feedback tap on seeded instance
        go(16'd1);
        chk("fb_seed", 32'(signature2), 32'h20400);
        beat(18'h00000);
        chk("fb_sig", 32'(signature2), 32'h00800);
        chk("fb_done", 32'(done2), 32'd1);

        // backpressure and gaps
        go(16'd4);
        j = 0;
        for (int i = 0; i < 6; i++) begin
            in_valid = pat[i];
            in_data  = pat[i] ? vecs[j] : 18'h15A5A;
            tick();
            if (pat[i]) j++;
        end
        in_valid = 1'b0;
        chk("gap_done", 32'(done), 32'd1);
        chk("gap_vec", 32'(vec_count), 32'd4);
        chk("gap_hit", 32'(hit_count), 32'd2);
        chk("gap_sig", 32'(signature), 32'h3FFF3);
        in_valid = 1'b1;
        in_data  = 18'h12345;
        tick(); tick();
        in_valid = 1'b0;
        chk("dn_sig", 32'(signature), 32'h3FFF3);
        chk("dn_vec", 32'(vec_count), 32'd4);
        chk("dn_done", 32'(done), 32'd1);

        // gap-free run of the same vectors, restarted from DONE
        go(16'd4);
        chk("nf_vec0", 32'(vec_count), 32'd0);
        for (int i = 0; i < 4; i++) beat(vecs[i]);
        chk("nf_sig", 32'(signature), 32'h3FFF3);
        chk("nf_done", 32'(done), 32'd1);

        // zero length and restart
        go(16'd0);
        chk("z_done", 32'(done), 32'd1);
        chk("z_busy", 32'(busy), 32'd0);
        chk("z_sig2", 32'(signature2), 32'h20400);
        chk("z_vec", 32'(vec_count), 32'd0);
        go(16'd2);
        chk("rs_busy", 32'(busy), 32'd1);
        chk("rs_vec", 32'(vec_count), 32'd0);
        chk("rs_hit", 32'(hit_count), 32'd0);
        beat(18'h20000);
        chk("rs_sig1", 32'(signature), 32'h20000);
        beat(18'h20000);
        chk("rs_sig2", 32'(signature), 32'h20001);
        chk("rs_hit2", 32'(hit_count), 32'd2);
        chk("rs_done", 32'(done), 32'd1);

        // abort collides with start and a beat
        go(16'd5);
        beat(18'h00001);
        chk("ab_pre", 32'(vec_count), 32'd1);
        abort = 1'b1; start = 1'b1; in_valid = 1'b1; in_data = 18'h00002;
        tick();
        abort = 1'b0; start = 1'b0; in_valid = 1'b0;
        chk("ab_busy", 32'(busy), 32'd0);
        chk("ab_done", 32'(done), 32'd0);
        chk("ab_ready", 32'(in_ready), 32'd0);
        chk("ab_vec", 32'(vec_count), 32'd1);
        chk("ab_sig", 32'(signature), 32'h00001);
        beat(18'h00004);
        chk("idle_vec", 32'(vec_count), 32'd1);

        // reset mid-run
        go(16'd5);
        beat(18'h00003);
        chk("mr_pre", 32'(vec_count), 32'd1);
        reset = 1'b1; in_valid = 1'b1; in_data = 18'h00005;
        tick(); tick();
        reset = 1'b0; in_valid = 1'b0;
        chk("mr_busy", 32'(busy), 32'd0);
        chk("mr_done", 32'(done), 32'd0);
        chk("mr_ready", 32'(in_ready), 32'd0);
        chk("mr_sig", 32'(signature), 32'd0);
        chk("mr_vec", 32'(vec_count), 32'd0);
        chk("mr_hit", 32'(hit_count), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
